// File: rtl/axi4_slave_mem_bridge.sv
// AXI4 slave to SRAM-style bridge. Handles FIXED/INCR/WRAP bursts including
// narrow and unaligned transfers, decodes a single address window (DECERR),
// flags protocol violations (SLVERR) and buffers read data in a credit-managed
// FIFO so that RREADY backpressure never drops or duplicates a beat.
module axi4_slave_mem_bridge #(
  parameter int                 ID_BW      = 4,
  parameter int                 ADDR_BW    = 32,
  parameter int                 DATA_BW    = 32,
  parameter int                 STRB_BW    = DATA_BW / 8,
  parameter logic [ADDR_BW-1:0] BASE_ADDR  = '0,
  parameter int                 MEM_BYTES  = 4096,
  parameter int                 RD_LAT     = 1,
  parameter int                 RBUF_DEPTH = 4
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [ID_BW-1:0]   AWID,
  input  logic [ADDR_BW-1:0] AWADDR,
  input  logic [7:0]         AWLEN,
  input  logic [2:0]         AWSIZE,
  input  logic [1:0]         AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [DATA_BW-1:0] WDATA,
  input  logic [STRB_BW-1:0] WSTRB,
  input  logic               WLAST,
  input  logic               WVALID,
  output logic               WREADY,
  output logic [ID_BW-1:0]   BID,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  input  logic [ID_BW-1:0]   ARID,
  input  logic [ADDR_BW-1:0] ARADDR,
  input  logic [7:0]         ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [ID_BW-1:0]   RID,
  output logic [DATA_BW-1:0] RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  output logic               o_w_en,
  output logic [ADDR_BW-1:0] o_w_addr,
  output logic [DATA_BW-1:0] o_w_data,
  output logic [STRB_BW-1:0] o_w_strb,
  output logic               o_r_en,
  output logic [ADDR_BW-1:0] o_r_addr,
  input  logic [DATA_BW-1:0] i_r_data
);

  localparam int               SIZE_MAX = $clog2(STRB_BW);
  localparam logic [1:0]       RESP_OKAY = 2'b00;
  localparam logic [1:0]       RESP_SLV  = 2'b10;
  localparam logic [1:0]       RESP_DEC  = 2'b11;
  localparam logic [1:0]       BURST_FIXED = 2'b00;
  localparam logic [1:0]       BURST_WRAP  = 2'b10;
  localparam logic [ADDR_BW:0] WIN_SIZE = (ADDR_BW+1)'(MEM_BYTES);
  localparam int               CW = $clog2(RBUF_DEPTH + RD_LAT + 2);
  localparam int               PW = (RBUF_DEPTH > 1) ? $clog2(RBUF_DEPTH) : 1;
  localparam int               EW = ID_BW + 2 + 1 + DATA_BW;
  localparam int               LAST_STG = RD_LAT - 1;

  // Window check done with a borrow bit so no comparison folds to a constant.
  function automatic logic in_window(input logic [ADDR_BW-1:0] a);
    logic [ADDR_BW:0] d;
    d = {1'b0, a} - {1'b0, BASE_ADDR};
    return !d[ADDR_BW] && (d < WIN_SIZE);
  endfunction

  // Burst-level protocol violations that suppress every memory access.
  function automatic logic static_bad(input logic [2:0] size, input logic [7:0] len,
                                      input logic [1:0] burst);
    logic bad;
    bad = 1'b0;
    if (size > 3'(SIZE_MAX)) bad = 1'b1;
    if (burst == 2'b11) bad = 1'b1;
    if (burst == BURST_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      bad = 1'b1;
    return bad;
  endfunction

  // Address of the following beat; aligning the current address first makes
  // an unaligned start only affect beat 0.
  function automatic logic [ADDR_BW-1:0] next_addr(input logic [ADDR_BW-1:0] cur,
                                                   input logic [2:0] size,
                                                   input logic [7:0] len,
                                                   input logic [1:0] burst);
    logic [ADDR_BW-1:0] bytes, nxt, blk, lower;
    bytes = ADDR_BW'(1) << size;
    nxt   = (cur & ~(bytes - ADDR_BW'(1))) + bytes;
    blk   = bytes * (ADDR_BW'(len) + ADDR_BW'(1));
    lower = cur & ~(blk - ADDR_BW'(1));
    if (burst == BURST_FIXED) nxt = cur;
    else if (burst == BURST_WRAP && nxt == lower + blk) nxt = lower;
    return nxt;
  endfunction

  function automatic logic [1:0] resp_of(input logic dec, input logic slv);
    return dec ? RESP_DEC : (slv ? RESP_SLV : RESP_OKAY);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RBUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // READY outputs stay low during reset and rise one edge after release.
  logic rdy_en;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  // ---------------------------------------------------------------- write path
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t           w_state, w_state_nxt;
  logic [ID_BW-1:0]   w_id;
  logic [ADDR_BW-1:0] w_addr;
  logic [7:0]         w_len, w_cnt;
  logic [2:0]         w_size;
  logic [1:0]         w_burst;
  logic               w_bad, w_dec, w_slv;
  logic               w_last, w_beat_ok;

  assign w_last    = (w_cnt == w_len);
  assign w_beat_ok = !w_bad && in_window(w_addr);

  // Write FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  // Write FSM next state and handshake outputs.
  always_comb begin
    w_state_nxt = w_state;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = rdy_en;
        if (AWVALID && rdy_en) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_last) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write burst context: latched on AW, advanced on every W beat, sticky errors.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_id <= '0; w_addr <= '0; w_len <= '0; w_cnt <= '0;
      w_size <= '0; w_burst <= '0; w_bad <= 1'b0; w_dec <= 1'b0; w_slv <= 1'b0;
    end else if (AWVALID && AWREADY) begin
      w_id    <= AWID;
      w_addr  <= AWADDR;
      w_len   <= AWLEN;
      w_size  <= AWSIZE;
      w_burst <= AWBURST;
      w_cnt   <= '0;
      w_bad   <= static_bad(AWSIZE, AWLEN, AWBURST);
      w_slv   <= static_bad(AWSIZE, AWLEN, AWBURST);
      w_dec   <= 1'b0;
    end else if (WVALID && WREADY) begin
      w_cnt  <= w_cnt + 8'd1;
      w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
      if (!in_window(w_addr)) w_dec <= 1'b1;
      if (WLAST != w_last)    w_slv <= 1'b1;
    end
  end

  assign o_w_en   = WVALID && WREADY && w_beat_ok;
  assign o_w_addr = (w_state == W_DATA) ? (w_addr - BASE_ADDR) : '0;
  assign o_w_data = WREADY ? WDATA : '0;
  assign o_w_strb = WREADY ? WSTRB : '0;
  assign BID      = w_id;
  assign BRESP    = BVALID ? resp_of(w_dec, w_slv) : RESP_OKAY;

  // ----------------------------------------------------------------- read path
  typedef enum logic {R_IDLE, R_ISSUE} r_state_t;
  r_state_t           r_state, r_state_nxt;
  logic [ID_BW-1:0]   r_id;
  logic [ADDR_BW-1:0] r_addr;
  logic [7:0]         r_len, r_cnt;
  logic [2:0]         r_size;
  logic [1:0]         r_burst;
  logic               r_bad, r_dec;
  logic               r_last, r_beat_ok, r_beat_dec, r_room, r_issue, r_pop, r_push;
  logic [CW-1:0]      inflight, fifo_cnt, occ;

  logic               tag_vld  [RD_LAT];
  logic [ID_BW-1:0]   tag_id   [RD_LAT];
  logic               tag_last [RD_LAT];
  logic [1:0]         tag_resp [RD_LAT];
  logic               tag_zero [RD_LAT];

  logic [EW-1:0]      fifo_mem [RBUF_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [EW-1:0]      head;

  assign r_last     = (r_cnt == r_len);
  assign r_beat_dec = r_dec || !in_window(r_addr);
  assign r_beat_ok  = !r_bad && in_window(r_addr);
  assign r_pop      = RVALID && RREADY;
  assign r_push     = tag_vld[LAST_STG];

  // Slots already committed: buffered entries plus beats still in the memory pipe.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_LAT; k++) inflight = inflight + CW'(tag_vld[k]);
  end

  // A pop this cycle frees its slot immediately, which keeps one beat per
  // cycle flowing when RBUF_DEPTH >= RD_LAT+1.
  assign occ     = fifo_cnt + inflight;
  assign r_room  = occ < (CW'(RBUF_DEPTH) + CW'(r_pop));
  assign r_issue = (r_state == R_ISSUE) && r_room;

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  // Read FSM next state and AR handshake.
  always_comb begin
    r_state_nxt = r_state;
    ARREADY     = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = rdy_en;
        if (ARVALID && rdy_en) r_state_nxt = R_ISSUE;
      end
      R_ISSUE: begin
        if (r_room && r_last) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read burst context: latched on AR, advanced per issued slot.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0;
      r_size <= '0; r_burst <= '0; r_bad <= 1'b0; r_dec <= 1'b0;
    end else if (ARVALID && ARREADY) begin
      r_id    <= ARID;
      r_addr  <= ARADDR;
      r_len   <= ARLEN;
      r_size  <= ARSIZE;
      r_burst <= ARBURST;
      r_cnt   <= '0;
      r_bad   <= static_bad(ARSIZE, ARLEN, ARBURST);
      r_dec   <= 1'b0;
    end else if (r_issue) begin
      r_cnt  <= r_cnt + 8'd1;
      r_addr <= next_addr(r_addr, r_size, r_len, r_burst);
      r_dec  <= r_beat_dec;
    end
  end

  assign o_r_en   = r_issue && r_beat_ok;
  assign o_r_addr = (r_state == R_ISSUE) ? (r_addr - BASE_ADDR) : '0;

  // Tag pipe valid bits: one stage per cycle of memory latency.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int k = 0; k < RD_LAT; k++) tag_vld[k] <= 1'b0;
    end else begin
      tag_vld[0] <= r_issue;
      for (int k = 1; k < RD_LAT; k++) tag_vld[k] <= tag_vld[k-1];
    end
  end

  // Tag pipe payload travelling alongside the valid bits.
  always_ff @(posedge ACLK) begin
    tag_id[0]   <= r_id;
    tag_last[0] <= r_last;
    tag_resp[0] <= resp_of(r_beat_dec, r_bad);
    tag_zero[0] <= !r_beat_ok;
    for (int k = 1; k < RD_LAT; k++) begin
      tag_id[k]   <= tag_id[k-1];
      tag_last[k] <= tag_last[k-1];
      tag_resp[k] <= tag_resp[k-1];
      tag_zero[k] <= tag_zero[k-1];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (r_push) wr_ptr <= ptr_inc(wr_ptr);
      if (r_pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(r_push) - CW'(r_pop);
    end
  end

  // FIFO storage; suppressed beats carry zero data.
  always_ff @(posedge ACLK) begin
    if (r_push)
      fifo_mem[wr_ptr] <= {tag_id[LAST_STG], tag_resp[LAST_STG], tag_last[LAST_STG],
                           tag_zero[LAST_STG] ? {DATA_BW{1'b0}} : i_r_data};
  end

  assign head   = fifo_mem[rd_ptr];
  assign RVALID = (fifo_cnt != '0);
  assign RDATA  = RVALID ? head[DATA_BW-1:0] : '0;
  assign RLAST  = RVALID && head[DATA_BW];
  assign RRESP  = RVALID ? head[DATA_BW+2:DATA_BW+1] : RESP_OKAY;
  assign RID    = RVALID ? head[EW-1 -: ID_BW] : '0;

endmodule

// File: tb/tb_axi4_slave_mem_bridge.sv
// Scoreboard bench for axi4_slave_mem_bridge: stimulus pushes hand-computed
// expectations, monitors on the falling edge pop and compare them.
module tb_axi4_slave_mem_bridge;
  localparam int ID_BW = 4, ADDR_BW = 32, DATA_BW = 32, STRB_BW = 4;
  localparam int RD_LAT = 3, RBUF_DEPTH = 4;

  logic ACLK, ARESETn;
  logic [3:0] AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA, o_w_addr, o_w_data, o_r_addr, i_r_data;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0] WSTRB, o_w_strb;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY, o_w_en, o_r_en;

  axi4_slave_mem_bridge #(
    .ID_BW(ID_BW), .ADDR_BW(ADDR_BW), .DATA_BW(DATA_BW), .STRB_BW(STRB_BW),
    .BASE_ADDR(32'h0), .MEM_BYTES(4096), .RD_LAT(RD_LAT), .RBUF_DEPTH(RBUF_DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .o_w_en(o_w_en), .o_w_addr(o_w_addr), .o_w_data(o_w_data), .o_w_strb(o_w_strb),
    .o_r_en(o_r_en), .o_r_addr(o_r_addr), .i_r_data(i_r_data)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Memory model: read data encodes the address it was read from.
  logic [31:0] rpipe [RD_LAT];
  always @(posedge ACLK) begin
    rpipe[0] <= o_r_en ? (32'hD000_0000 | o_r_addr) : 32'hDEAD_BEEF;
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign i_r_data = rpipe[RD_LAT-1];

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wexp_t;

  wexp_t       exp_w [$];
  logic [5:0]  exp_b [$];
  logic [38:0] exp_r [$];
  logic [31:0] exp_ra[$];
  int n_chk = 0, n_fail = 0;
  bit ign_rd = 1'b0;
  int rmode = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Scoreboard monitors.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (WVALID && WREADY) begin
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else begin
          wexp_t e;
          e = exp_w.pop_front();
          check("w_en", o_w_en, e.en);
          if (e.en) check("w_beat", {o_w_addr, o_w_data, o_w_strb}, {e.addr, e.data, e.strb});
        end
      end
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) check("b_unexpected", 1, 0);
        else check("b_resp", {BID, BRESP}, exp_b.pop_front());
      end
      if (o_r_en && !ign_rd) begin
        if (exp_ra.size() == 0) check("r_en_unexpected", 1, 0);
        else check("r_addr", o_r_addr, exp_ra.pop_front());
      end
      if (RVALID && RREADY) begin
        if (exp_r.size() == 0) check("r_unexpected", 1, 0);
        else check("r_beat", {RID, RRESP, RLAST, RDATA}, exp_r.pop_front());
      end
    end
  end

  // RREADY pattern: 0 = always high, 1 = toggle, 2 = always low.
  initial begin
    RREADY = 1'b1;
    forever begin
      @(posedge ACLK); #1;
      case (rmode)
        1:       RREADY = ~RREADY;
        2:       RREADY = 1'b0;
        default: RREADY = 1'b1;
      endcase
    end
  end

  function automatic void push_w(input logic en, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
    wexp_t e;
    e.en = en; e.addr = a; e.data = d; e.strb = s;
    exp_w.push_back(e);
  endfunction

  function automatic void push_r(input logic [3:0] id, input logic [1:0] rs, input logic l,
                                 input logic [31:0] d);
    exp_r.push_back({id, rs, l, d});
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // Wait for a handshake on channel sel (0 AW, 1 W, 2 AR); returns at posedge+1.
  task automatic wait_hs(input int sel, input string nm);
    bit hs;
    int t;
    t = 0;
    do begin
      @(negedge ACLK);
      hs = (sel == 0) ? AWREADY : (sel == 1) ? WREADY : ARREADY;
      @(posedge ACLK); #1;
      t++;
    end while (!hs && t < 200);
    if (!hs) check(nm, 0, 1);
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    AWID = id; AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    wait_hs(0, "aw_timeout");
    AWVALID = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    wait_hs(2, "ar_timeout");
    ARVALID = 1'b0;
  endtask

  task automatic send_w(input int n, input logic [31:0] d0, input logic [3:0] s, input int lastpos);
    for (int i = 0; i < n; i++) begin
      WDATA = d0 + 32'(i); WSTRB = s; WLAST = (i == lastpos); WVALID = 1'b1;
      wait_hs(1, "w_timeout");
    end
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic drain(input string nm, input int lim);
    int t;
    t = 0;
    while ((exp_w.size() + exp_b.size() + exp_r.size() + exp_ra.size()) != 0 && t < lim) begin
      @(posedge ACLK);
      t++;
    end
    #1;
    check(nm, exp_w.size() + exp_b.size() + exp_r.size() + exp_ra.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    wait_cyc(3);
    check("reset_outputs",
          {AWREADY, WREADY, BVALID, ARREADY, RVALID, o_w_en, o_r_en, BRESP, RRESP, BID, RID},
          '0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("awready_before_edge", AWREADY, 0);
    wait_cyc(1);
    check("awready_after_release", {AWREADY, ARREADY}, 2'b11);

    // INCR write, 4 beats
    for (int i = 0; i < 4; i++) push_w(1, 32'h10 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF);
    exp_b.push_back({4'h3, 2'b00});
    do_aw(4'h3, 32'h10, 8'd3, 3'd2, 2'b01);
    send_w(4, 32'hA000_0000, 4'hF, 3);
    drain("drain_incr_write", 50);

    // WRAP read from 0x38
    exp_ra.push_back(32'h38); exp_ra.push_back(32'h3C);
    exp_ra.push_back(32'h30); exp_ra.push_back(32'h34);
    push_r(4'h5, 2'b00, 0, 32'hD000_0038); push_r(4'h5, 2'b00, 0, 32'hD000_003C);
    push_r(4'h5, 2'b00, 0, 32'hD000_0030); push_r(4'h5, 2'b00, 1, 32'hD000_0034);
    do_ar(4'h5, 32'h38, 8'd3, 3'd2, 2'b10);
    drain("drain_wrap_read", 50);

    // 16-beat INCR read under toggling RREADY
    for (int i = 0; i < 16; i++) begin
      exp_ra.push_back(32'h100 + 32'(4*i));
      push_r(4'h6, 2'b00, i == 15, 32'hD000_0100 + 32'(4*i));
    end
    rmode = 1;
    do_ar(4'h6, 32'h100, 8'd15, 3'd2, 2'b01);
    drain("drain_backpressure_read", 300);
    rmode = 0;
    wait_cyc(2);

    // Burst crossing the top of the window
    push_w(1, 32'hFFC, 32'hB000_0000, 4'hF);
    push_w(0, 32'h1000, 32'hB000_0001, 4'hF);
    exp_b.push_back({4'h7, 2'b11});
    do_aw(4'h7, 32'hFFC, 8'd1, 3'd2, 2'b01);
    send_w(2, 32'hB000_0000, 4'hF, 1);

    // Early WLAST
    for (int i = 0; i < 4; i++) push_w(1, 32'h40 + 32'(4*i), 32'hC000_0000 + 32'(i), 4'hF);
    exp_b.push_back({4'h8, 2'b10});
    do_aw(4'h8, 32'h40, 8'd3, 3'd2, 2'b01);
    send_w(4, 32'hC000_0000, 4'hF, 1);

    // FIXED narrow write
    for (int i = 0; i < 3; i++) push_w(1, 32'h20, 32'hE000_0000 + 32'(i), 4'h3);
    exp_b.push_back({4'h2, 2'b00});
    do_aw(4'h2, 32'h20, 8'd2, 3'd1, 2'b00);
    send_w(3, 32'hE000_0000, 4'h3, 2);

    // Unaligned narrow INCR write
    push_w(1, 32'h21, 32'hF000_0000, 4'h6);
    push_w(1, 32'h22, 32'hF000_0001, 4'h6);
    push_w(1, 32'h24, 32'hF000_0002, 4'h6);
    exp_b.push_back({4'h1, 2'b00});
    do_aw(4'h1, 32'h21, 8'd2, 3'd1, 2'b01);
    send_w(3, 32'hF000_0000, 4'h6, 2);

    // Reserved burst type: all accesses suppressed
    push_w(0, 32'h50, 32'h1234_0000, 4'hF);
    push_w(0, 32'h54, 32'h1234_0001, 4'hF);
    exp_b.push_back({4'hB, 2'b10});
    do_aw(4'hB, 32'h50, 8'd1, 3'd2, 2'b11);
    send_w(2, 32'h1234_0000, 4'hF, 1);
    drain("drain_error_writes", 50);

    // Oversized read: zero data, no memory access
    push_r(4'h9, 2'b10, 0, 32'h0); push_r(4'h9, 2'b10, 1, 32'h0);
    do_ar(4'h9, 32'h80, 8'd1, 3'd3, 2'b01);
    // WRAP with illegal length
    push_r(4'hC, 2'b10, 0, 32'h0); push_r(4'hC, 2'b10, 0, 32'h0); push_r(4'hC, 2'b10, 1, 32'h0);
    do_ar(4'hC, 32'h90, 8'd2, 3'd2, 2'b10);
    drain("drain_error_reads", 80);

    // Reset in the middle of a read burst with data parked in the FIFO
    rmode = 2;
    wait_cyc(2);
    ign_rd = 1'b1;
    do_ar(4'h4, 32'h300, 8'd7, 3'd2, 2'b01);
    t = 0;
    while (!RVALID && t < 40) begin @(negedge ACLK); t++; end
    wait_cyc(3);
    check("rvalid_before_reset", RVALID, 1);
    ARESETn = 1'b0;
    #1;
    check("rvalid_in_reset", {RVALID, ARREADY, o_r_en}, 3'b000);
    exp_r.delete(); exp_ra.delete();
    wait_cyc(2);
    ARESETn = 1'b1;
    rmode = 0;
    ign_rd = 1'b0;
    @(negedge ACLK);
    check("arready_before_edge", ARREADY, 0);
    wait_cyc(1);
    check("arready_after_release", ARREADY, 1);
    wait_cyc(10);
    check("no_stale_rvalid", RVALID, 0);

    exp_ra.push_back(32'h200); exp_ra.push_back(32'h204);
    push_r(4'hA, 2'b00, 0, 32'hD000_0200); push_r(4'hA, 2'b00, 1, 32'hD000_0204);
    do_ar(4'hA, 32'h200, 8'd1, 3'd2, 2'b01);
    drain("drain_after_reset", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
